// File: rtl/dct2d_stream.sv
// dct2d_stream -- streaming 2D forward DCT, D = (C * X * C^T) >>> SHIFT.
//
// One NxN block at a time. Pixels are loaded serially, then a single
// multiply-accumulate unit runs the row pass (T = C * X) and the column
// pass (S = T * C^T). The coefficients then leave serially, saturated to OW bits.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; aborts any block in flight
//   in_valid   in_pixel is valid
//   in_ready   pixel accepted this cycle (high only while loading)
//   in_pixel   DW-bit pixel, raster order
//   out_valid  out_coef is valid
//   out_ready  downstream accepts the coefficient
//   out_coef   OW-bit signed coefficient, raster order (k row, l column)
//   out_last   marks the N*N-th coefficient of a block
//   busy       high whenever the engine is not loading
module dct2d_stream #(
    parameter int N     = 8,
    parameter int DW    = 8,
    parameter int CW    = 12,
    parameter int OW    = 16,
    parameter int SHIFT = 2 * (CW - 1) + 2,
    parameter int LVL   = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_pixel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_coef,
    output logic          out_last,
    output logic          busy
);

    localparam int LN   = $clog2(N);
    localparam int NN   = N * N;
    localparam int XW   = DW + 1;
    localparam int TW   = DW + 1 + CW + LN;
    localparam int PW   = TW + CW;
    localparam int AW   = DW + 1 + 2 * CW + 2 * LN;
    localparam int CNTW = 3 * LN + 1;

    localparam logic [2*LN-1:0]      LAST_IDX = {(2*LN){1'b1}};
    localparam logic [2*LN-1:0]      IDX_ONE  = (2*LN)'(1);
    localparam logic [CNTW-1:0]      CNT_ONE  = CNTW'(1);
    localparam logic signed [XW-1:0] OFFS     = XW'(1 << (DW - 1));
    localparam logic signed [AW-1:0] OMAX     = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] OMIN     = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    // Cosine evaluated by Taylor series so the ROM folds to constants at
    // elaboration. The angle is first reduced to [-pi, pi].
    function automatic int rom_val(input int k, input int n);
        real ang, x2, term, sum, v;
        int  m;
        m = ((2 * n + 1) * k) % (4 * N);
        if (m > 2 * N) m = m - 4 * N;
        ang  = 3.14159265358979323846 * m / (2.0 * N);
        x2   = ang * ang;
        term = 1.0;
        sum  = 1.0;
        for (int i = 1; i < 20; i++) begin
            term = -term * x2 / real'((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        v = sum * real'(1 << (CW - 1));
        if (k == 0) v = v * 0.70710678118654752440;
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    function automatic logic signed [OW-1:0] sat_ow(input logic signed [AW-1:0] v);
        if (v > OMAX) return OMAX[OW-1:0];
        if (v < OMIN) return OMIN[OW-1:0];
        return v[OW-1:0];
    endfunction

    typedef enum logic [1:0] {S_LOAD, S_ROW, S_COL, S_OUT} state_t;

    state_t                 state, state_n;
    logic [2*LN-1:0]        idx;
    logic [CNTW-1:0]        cnt;
    logic                   issue;

    logic signed [CW-1:0]   rom   [N][N];
    logic signed [XW-1:0]   x_mem [NN];
    logic signed [TW-1:0]   t_mem [NN];
    logic signed [OW-1:0]   d_mem [NN];
    logic signed [XW-1:0]   x_in;

    logic [LN-1:0]          f0, f1, f2;
    logic                   is_col_p0;
    logic signed [TW-1:0]   a_p0;
    logic signed [CW-1:0]   b_p0;
    logic signed [PW-1:0]   prod_p0;
    logic [2*LN-1:0]        dst_p0;

    logic signed [PW-1:0]   prod_p1;
    logic                   vld_p1, first_p1, last_p1, col_p1;
    logic [2*LN-1:0]        dst_p1;
    logic signed [AW-1:0]   acc, acc_n;

    for (genvar gk = 0; gk < N; gk++) begin : g_rom_k
        for (genvar gn = 0; gn < N; gn++) begin : g_rom_n
            localparam int CV = rom_val(gk, gn);
            assign rom[gk][gn] = CV[CW-1:0];
        end
    end

    assign x_in = (LVL != 0) ? signed'({1'b0, in_pixel}) - OFFS
                             : signed'({in_pixel[DW-1], in_pixel});

    // Loop fields: f0 is the summation index in both passes.
    // Row pass:    f2 = k, f1 = c, f0 = n  -> T[k][c] += C[k][n] * X[n][c]
    // Column pass: f2 = k, f1 = l, f0 = c  -> S[k][l] += T[k][c] * C[l][c]
    assign f0    = cnt[LN-1:0];
    assign f1    = cnt[2*LN-1:LN];
    assign f2    = cnt[3*LN-1:2*LN];
    assign issue = (state == S_ROW) || (state == S_COL && !cnt[3*LN]);

    always_ff @(posedge clk) begin
        if (reset) state <= S_LOAD;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && idx == LAST_IDX) state_n = S_ROW;
            end
            S_ROW: if (&cnt[3*LN-1:0]) state_n = S_COL;
            // The pass ends when the final D element leaves the accumulator.
            S_COL: if (vld_p1 && last_p1 && col_p1 && dst_p1 == LAST_IDX) state_n = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready && idx == LAST_IDX) state_n = S_LOAD;
            end
            default: state_n = S_LOAD;
        endcase
    end

    assign out_coef = (state == S_OUT) ? d_mem[idx] : '0;
    assign out_last = (state == S_OUT) && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx    <= '0;
            cnt    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue;
            unique case (state)
                S_LOAD: begin
                    cnt <= '0;
                    if (in_valid) idx <= idx + IDX_ONE;
                end
                S_ROW:   cnt <= (&cnt[3*LN-1:0]) ? '0 : cnt + CNT_ONE;
                S_COL:   if (!cnt[3*LN]) cnt <= cnt + CNT_ONE;
                S_OUT:   if (out_ready) idx <= idx + IDX_ONE;
                default: ;
            endcase
        end
    end

    // Stage p0: operand fetch and multiply
    always_comb begin
        is_col_p0 = (state == S_COL);
        dst_p0    = {f2, f1};
        if (is_col_p0) begin
            a_p0 = t_mem[{f2, f0}];
            b_p0 = rom[f1][f0];
        end else begin
            a_p0 = TW'(x_mem[{f0, f1}]);
            b_p0 = rom[f2][f0];
        end
    end

    assign prod_p0 = PW'(a_p0) * PW'(b_p0);

    // Stage p1: accumulate; the last term of a sum writes straight to memory
    assign acc_n = first_p1 ? AW'(prod_p1) : acc + AW'(prod_p1);

    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) x_mem[idx] <= x_in;
        if (issue) begin
            prod_p1  <= prod_p0;
            first_p1 <= (f0 == '0);
            last_p1  <= &f0;
            col_p1   <= is_col_p0;
            dst_p1   <= dst_p0;
        end
        if (vld_p1) begin
            acc <= acc_n;
            if (last_p1) begin
                if (col_p1) d_mem[dst_p1] <= sat_ow(acc_n >>> SHIFT);
                else        t_mem[dst_p1] <= acc_n[TW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_dct2d_stream.sv
// Testbench for dct2d_stream: three instances (N=8/OW=16, N=8/OW=10,
// N=4/OW=16) share clock and reset; each block is compared against a
// direct double-sum DCT model with floor shift and saturation.
module tb_dct2d_stream;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        ivl, ordy;
    logic [7:0]        ipx [3];
    logic [2:0]        ir, ov, ol, bz;
    logic signed [15:0] oc0, oc2;
    logic signed [9:0]  oc1;

    int     cyc = 0;
    int     n_assert = 0;
    int     n_fail = 0;
    int     px [64];
    longint expd [64];
    longint gotv [64];
    longint t_last;
    int     row1 [8] = '{2009, 1703, 1138, 400, -400, -1138, -1703, -2009};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dct2d_stream #(.N(8), .OW(16)) u8 (
        .clk(clk), .reset(reset), .in_valid(ivl[0]), .in_ready(ir[0]), .in_pixel(ipx[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_coef(oc0), .out_last(ol[0]), .busy(bz[0]));

    dct2d_stream #(.N(8), .OW(10)) u8s (
        .clk(clk), .reset(reset), .in_valid(ivl[1]), .in_ready(ir[1]), .in_pixel(ipx[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_coef(oc1), .out_last(ol[1]), .busy(bz[1]));

    dct2d_stream #(.N(4), .OW(16)) u4 (
        .clk(clk), .reset(reset), .in_valid(ivl[2]), .in_ready(ir[2]), .in_pixel(ipx[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_coef(oc2), .out_last(ol[2]), .busy(bz[2]));

    function automatic int nsz(input int d);
        return (d == 2) ? 4 : 8;
    endfunction

    function automatic int owd(input int d);
        return (d == 1) ? 10 : 16;
    endfunction

    function automatic logic signed [15:0] get_oc(input int d);
        if (d == 0) return oc0;
        if (d == 1) return 16'(oc1);
        return oc2;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int coef(input int n, input int k, input int i);
        real a, v;
        a = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v = 2048.0 * a * $cos(real'((2 * i + 1) * k) * 3.14159265358979323846 / (2.0 * n));
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    // D[k][l] = floor(sum_n sum_c C[k][n] X[n][c] C[l][c] / 2^24), clamped to OW bits
    function automatic void model(input int d);
        int     n;
        longint s, lo, hi;
        n  = nsz(d);
        hi = (longint'(1) <<< (owd(d) - 1)) - 1;
        lo = -(longint'(1) <<< (owd(d) - 1));
        for (int k = 0; k < n; k++)
            for (int l = 0; l < n; l++) begin
                s = 0;
                for (int r = 0; r < n; r++)
                    for (int c = 0; c < n; c++)
                        s += longint'(coef(n, k, r)) * (px[r * n + c] - 128) * coef(n, l, c);
                s = s >>> 24;
                if (s > hi) s = hi;
                if (s < lo) s = lo;
                expd[k * n + l] = s;
            end
    endfunction

    task automatic send_block(input int d, input int cnt, input bit gaps);
        int  i = 0;
        bit  acc;
        for (int cy = 0; cy < 4000 && i < cnt; cy++) begin
            if (gaps && $urandom_range(0, 99) < 30) begin
                ivl[d] = 1'b0;
            end else begin
                ivl[d] = 1'b1;
                ipx[d] = 8'(px[i]);
            end
            acc = ivl[d] && ir[d];
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                t_last = cyc;
            end
        end
        ivl[d] = 1'b0;
        chk("pixels_sent", i, cnt);
    endtask

    task automatic recv_block(input int d, input int pct);
        int   n, nn, got;
        bit   first_seen, stalled;
        logic signed [15:0] held;
        logic held_last;
        n = nsz(d);
        nn = n * n;
        got = 0;
        first_seen = 0;
        stalled = 0;
        held = '0;
        held_last = 1'b0;
        for (int cy = 0; cy < 6000 && got < nn; cy++) begin
            ordy[d] = ($urandom_range(0, 99) < pct);
            chk("in_ready_low", ir[d], 0);
            chk("busy_high", bz[d], 1);
            if (ov[d]) begin
                if (!first_seen) begin
                    first_seen = 1;
                    chk("latency", cyc - t_last, 2 * n * n * n + 1);
                end
                if (stalled) begin
                    chk("hold_coef", get_oc(d), held);
                    chk("hold_last", ol[d], held_last);
                end
                if (ordy[d]) begin
                    gotv[got] = get_oc(d);
                    chk($sformatf("coef[%0d]", got), get_oc(d), expd[got]);
                    chk($sformatf("last[%0d]", got), ol[d], (got == nn - 1));
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = get_oc(d);
                    held_last = ol[d];
                end
            end else if (stalled) begin
                chk("valid_dropped", ov[d], 1);
            end
            @(posedge clk);
            #1;
        end
        ordy[d] = 1'b0;
        chk("coef_count", got, nn);
        chk("in_ready_after", ir[d], 1);
        chk("busy_after", bz[d], 0);
        chk("valid_after", ov[d], 0);
    endtask

    task automatic run_block(input int d, input bit gaps, input int pct);
        send_block(d, nsz(d) * nsz(d), gaps);
        model(d);
        recv_block(d, pct);
    endtask

    task automatic fill(input int mode, input int val);
        for (int i = 0; i < 64; i++)
            px[i] = (mode == 0) ? val : (mode == 1) ? int'($urandom_range(0, 255)) : (i * 16) % 256;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, ir[0], 1);
        chk({tag, "_out_valid"}, ov[0], 0);
        chk({tag, "_busy"}, bz[0], 0);
        chk({tag, "_coef"}, oc0, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vcount;
        ivl  = '0;
        ordy = '0;
        for (int d = 0; d < 3; d++) ipx[d] = '0;
        t_last = 0;

        // reset state, sampled while reset is held
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready", ir[d], 1);
            chk("rst_out_valid", ov[d], 0);
            chk("rst_out_last", ol[d], 0);
            chk("rst_busy", bz[d], 0);
            chk("rst_coef", get_oc(d), 0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;

        // coefficient ROM contents
        for (int i = 0; i < 8; i++) chk("rom8_row1", u8.rom[1][i], row1[i]);
        for (int i = 0; i < 4; i++) chk("rom4_row0", u4.rom[0][i], 1448);

        // flat mid-grey block
        fill(0, 128);
        run_block(0, 0, 100);

        // full-scale flat blocks
        fill(0, 255);
        run_block(0, 0, 100);
        chk("dc_255", gotv[0], 1015);
        fill(0, 0);
        run_block(0, 0, 100);
        chk("dc_0", gotv[0], -1024);

        // saturation at OW=10
        fill(0, 255);
        run_block(1, 0, 100);
        chk("sat_dc_255", gotv[0], 511);
        fill(0, 0);
        run_block(1, 0, 100);
        chk("sat_dc_0", gotv[0], -512);

        // random blocks with gapped input and backpressure
        for (int b = 0; b < 3; b++) begin
            fill(1, 0);
            run_block(0, 1, 40);
        end
        fill(1, 0);
        run_block(1, 1, 40);

        // reset after 30 pixels
        fill(1, 0);
        send_block(0, 30, 0);
        pulse_reset();
        check_idle("rst_load");
        fill(0, 128);
        run_block(0, 0, 100);

        // reset during the column pass
        fill(1, 0);
        send_block(0, 64, 0);
        repeat (562) @(posedge clk);
        #1;
        chk("col_busy", bz[0], 1);
        chk("col_in_ready", ir[0], 0);
        pulse_reset();
        check_idle("rst_col");
        vcount = 0;
        for (int cy = 0; cy < 1100; cy++) begin
            ordy[0] = 1'b1;
            if (ov[0]) vcount++;
            @(posedge clk);
            #1;
        end
        ordy[0] = 1'b0;
        chk("no_stale_output", vcount, 0);
        fill(0, 128);
        run_block(0, 0, 100);

        // N=4: ramp block, then a random block with backpressure
        fill(2, 0);
        run_block(2, 0, 100);
        fill(1, 0);
        run_block(2, 1, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dct2d_stream.md
Name: dct2d_stream

Overview:
Parametrised, streaming 2D forward DCT engine computing D = (C·X·Cᵀ) >>> SHIFT on one NxN pixel block at a time.
- Pixels enter serially over a valid/ready handshake and are level-shifted.
- A single multiply-accumulate unit performs the row pass, then the column pass.
- Coefficients leave serially over a second valid/ready handshake with saturation.
- The block sits between the pixel block buffer and the quantiser in the image-compression datapath.

Parameters:
N, 8, transform size; legal values 4 or 8.
DW, 8, input pixel width in bits.
CW, 12, signed coefficient width.
OW, 16, signed output coefficient width.
SHIFT, 2*(CW-1)+2, arithmetic right shift applied to the final 2D sum.
LVL, 1, 1 = unsigned pixels minus 2^(DW-1); 0 = pixels are already two's-complement signed.

Ports:
clk  in  1  single clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  in_pixel is valid.
in_ready  out  1  block accepts a pixel this cycle.
in_pixel  in  DW  pixel, raster order (row 0 col 0 first).
out_valid  out  1  out_coef is valid.
out_ready  in  1  downstream accepts the coefficient.
out_coef  out  OW  signed DCT coefficient, raster order (k row, l column).
out_last  out  1  high with the final (N*N-th) coefficient of a block.
busy  out  1  high in every state except LOAD.

Behaviour:
- Reset (synchronous): state=LOAD, all counters 0, in_ready=1, out_valid=0, out_coef=0, out_last=0, busy=0. Reset during any state aborts the block and discards partial data; nothing further is output for that block.
- Coefficient ROM, generated at elaboration: C[k][n] = round(2^(CW-1)·a_k·cos((2n+1)kπ/2N)), with a_0 = 1/√2 and a_k = 1 for k > 0.
  - For N=8, CW=12, row 1 is 2009, 1703, 1138, 400, -400, -1138, -1703, -2009.
- Handshakes: a transfer occurs when valid && ready are high on the same edge. While out_valid=1 and out_ready=0, out_coef and out_last hold stable. out_valid never drops without a transfer except on reset.
- States:
  - LOAD: in_ready=1. Each accepted pixel is stored as X[r][c] = pixel - 2^(DW-1) if LVL=1, else the signed pixel. The pixel index counter runs 0..N*N-1. Accepting index N*N-1 moves to ROW on the next edge; in_ready drops in the same cycle the state changes.
  - ROW: computes T[k][c] = Σn C[k][n]·X[n][c]. One MAC per cycle, N cycles per element, N^3 cycles total. T is kept at full precision with width DW+1+CW+log2(N); no rounding. Moves to COL.
  - COL: computes S[k][l] = Σc T[k][c]·C[l][c], also N^3 cycles. The accumulator is wide enough for no overflow: DW+1+2·CW+2·log2(N). Stores D[k][l] = sat_OW(S >>> SHIFT). The shift is arithmetic (floor toward -inf). Saturation clamps to [-2^(OW-1), 2^(OW-1)-1]. Moves to OUT.
  - OUT: out_valid=1 and presents D in raster order, advancing on each transfer. out_last=1 on index N*N-1. That transfer returns the block to LOAD, with in_ready=1 on the next cycle.
- Latency:
  - If the last pixel is accepted on edge t, out_valid is first high after edge t+2·N^3+1 (1025 cycles for N=8).
  - Minimum block period is N*N + 2·N^3 + N*N cycles.
  - in_ready stays 0 during ROW, COL and OUT; no overlap between blocks.
- in_valid is ignored outside LOAD. out_ready is ignored outside OUT.

Test Plan:
1. N=8, DW=8, LVL=1, 64 pixels of 128 → all 64 out_coef = 0; out_last only on the 64th; first out_valid 1025 cycles after the last input is accepted.
2. 64 pixels of 255 → D[0][0] = 1015 and all 63 AC = 0. 64 pixels of 0 → D[0][0] = -1024 (floor) and AC = 0.
3. Saturation, OW=10, all-255 block → D[0][0] = 511; all-0 block → D[0][0] = -512.
4. Backpressure: random out_ready (~40% duty) and gapped in_valid on a random block → out_coef holds while stalled; all 64 values match a bit-exact software model of the ROM, full-precision sums, floor shift and saturation; in_ready stays 0 until the final transfer.
5. Reset mid-operation: assert reset for one cycle after 30 pixels, and again during COL → next cycle out_valid=0, in_ready=1, busy=0; a following full block of 128s yields all zeros with no stale output.
6. N=4, CW=12 → ROM row 0 all 1448; a 16-pixel ramp block matches the model; latency is 2·64+1 cycles after the last input.
